oam_dma: RTL and testbench

- Sits directly downstream of the Cpu6502 bus outputs, between the CPU and the system address/data bus.
- Passes CPU bus cycles through unchanged until the CPU writes the sprite DMA register $4014.
- On that write, stalls the CPU via RDY and copies 256 bytes from page {value,8'h00} to OAMDATA ($2004), one read/write pair per byte.
- Returns bus ownership to the CPU when the copy completes.

---
 rtl/nes_bus_pkg.sv | 19 +
 rtl/oam_dma.sv | 86 ++++++++
 tb/tb_oam_dma.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// nes_bus_pkg: shared NES bus constants and the OAM DMA state encoding.
package nes_bus_pkg;
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic [15:0] ADDR_OAM_DMA = 16'h4014;
   localparam logic [15:0] ADDR_OAMDATA = 16'h2004;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HALT  = 3'd1;
   localparam logic [2:0] S_ALIGN = 3'd2;
   localparam logic [2:0] S_READ  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;
   typedef enum logic [2:0] {
      DMA_IDLE  = S_IDLE,
      DMA_HALT  = S_HALT,
      DMA_ALIGN = S_ALIGN,
      DMA_READ  = S_READ,
      DMA_WRITE = S_WRITE
   } dma_state_e;
endpackage

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA between the 6502 core and the system bus; stalls the CPU and copies a page to OAMDATA.
// Define OAM_DMA_ALIGN_EN to insert an ALIGN cycle so the first READ always lands on an even cycle.
module oam_dma
   import nes_bus_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAM_DMA,
   parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cpu_rw,
   input  logic [15:0] i_cpu_address,
   input  logic [7:0]  i_cpu_data,
   output logic        o_cpu_rdy,
   output logic        o_rw,
   output logic [15:0] o_address,
   output logic [7:0]  o_data,
   input  logic [7:0]  i_data,
   output logic        o_dma_active
);
   dma_state_e  state_q;
   logic [7:0]  page_q;
   logic [7:0]  idx_q;
   logic [7:0]  data_q;
   logic        rdy_q;
   logic        active_q;
`ifdef OAM_DMA_ALIGN_EN
   logic        parity_q;
`endif

   always_ff @(negedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q  <= DMA_IDLE;
         page_q   <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         rdy_q    <= 1'b1;
         active_q <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
         parity_q <= 1'b0;
`endif
      end else begin
`ifdef OAM_DMA_ALIGN_EN
         parity_q <= ~parity_q;
`endif
         case (state_q)
            DMA_IDLE:
               if (i_cpu_rw == RW_WRITE && i_cpu_address == DMA_REG_ADDR) begin
                  page_q   <= i_cpu_data;
                  idx_q    <= '0;
                  state_q  <= DMA_HALT;
                  rdy_q    <= 1'b0;
                  active_q <= 1'b1;
               end
`ifdef OAM_DMA_ALIGN_EN
            DMA_HALT:  state_q <= parity_q ? DMA_READ : DMA_ALIGN;
`else
            DMA_HALT:  state_q <= DMA_READ;
`endif
            DMA_ALIGN: state_q <= DMA_READ;
            DMA_READ: begin
               data_q  <= i_data;
               state_q <= DMA_WRITE;
            end
            DMA_WRITE: begin
               idx_q <= idx_q + 8'd1;
               if (idx_q == 8'hFF) begin
                  state_q  <= DMA_IDLE;
                  rdy_q    <= 1'b1;
                  active_q <= 1'b0;
               end else begin
                  state_q <= DMA_READ;
               end
            end
            default: state_q <= DMA_IDLE;
         endcase
      end
   end

   // HALT/ALIGN reuse the CPU address as a dummy read so the bus stays quiet
   assign o_rw         = state_q == DMA_IDLE ? i_cpu_rw : state_q == DMA_WRITE ? RW_WRITE : RW_READ;
   assign o_address    = state_q == DMA_READ ? {page_q, idx_q} : state_q == DMA_WRITE ? OAM_DATA_ADDR : i_cpu_address;
   assign o_data       = state_q == DMA_WRITE ? data_q : i_cpu_data;
   assign o_cpu_rdy    = rdy_q;
   assign o_dma_active = active_q;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized scoreboard bench for oam_dma against a cycle-schedule reference model.
module tb_oam_dma;
   logic        clk = 1'b1;
   logic        rst;
   logic        cpu_rw;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        rdy, rw, act;
   logic [15:0] addr;
   logic [7:0]  dout, din;

   typedef struct {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        chk_data;
      logic        rdy;
      logic        act;
   } exp_t;

   exp_t q[$];
   int errors = 0;
   int checks = 0;
   int ncyc = 0;
   int left = 0;
   int len = 0;
   logic [7:0] page = '0;

`ifdef OAM_DMA_ALIGN_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   function automatic logic [7:0] memf(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA7;
   endfunction

   assign din = memf(addr);

   oam_dma dut (
      .i_clk(clk), .i_reset(rst), .i_cpu_rw(cpu_rw), .i_cpu_address(cpu_addr),
      .i_cpu_data(cpu_data), .o_cpu_rdy(rdy), .o_rw(rw), .o_address(addr),
      .o_data(dout), .i_data(din), .o_dma_active(act)
   );

   always #5 clk = ~clk;

   task automatic check(input string n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", n, got, want);
      end
   endtask

   always @(posedge clk) begin
      if (!rst && q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (rw !== e.rw || addr !== e.addr || rdy !== e.rdy || act !== e.act || (e.chk_data && dout !== e.data)) begin
            errors++;
            $display("FAIL bus t=%0t: got rw=%b addr=%h data=%h rdy=%b act=%b want rw=%b addr=%h data=%h(chk=%b) rdy=%b act=%b",
                     $time, rw, addr, dout, rdy, act, e.rw, e.addr, e.data, e.chk_data, e.rdy, e.act);
         end
      end
   end

   // One CPU bus cycle: the model derives the expected bus from the DMA schedule position
   task automatic cyc(input logic r, input logic [15:0] a, input logic [7:0] d);
      exp_t e;
      int j, k, dd;
      logic [15:0] src;
      cpu_rw = r; cpu_addr = a; cpu_data = d;
      if (left == 0) begin
         e = '{r, a, d, 1'b1, 1'b1, 1'b0};
         if (!r && a == 16'h4014) begin
            len  = 513 + ((ALIGN_EN && ((ncyc + 1) % 2 == 0)) ? 1 : 0);
            left = len;
            page = d;
         end
      end else begin
         j  = len - left;
         dd = len - 512;
         if (j < dd) begin
            e = '{1'b1, a, 8'h00, 1'b0, 1'b0, 1'b1};
         end else begin
            k   = j - dd;
            src = {page, 8'(k / 2)};
            e   = (k % 2 == 0) ? '{1'b1, src, 8'h00, 1'b0, 1'b0, 1'b1}
                               : '{1'b0, 16'h2004, memf(src), 1'b1, 1'b0, 1'b1};
         end
         left--;
      end
      q.push_back(e);
      ncyc++;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic [15:0] a;
      repeat (n) begin
         a = 16'($urandom);
         if (a == 16'h4014 || a == 16'h2004) a = 16'h0300;
         cyc(1'($urandom), a, 8'($urandom));
      end
   endtask

   task automatic busy(input int n);
      repeat (n) begin
         if ($urandom_range(0, 7) == 0) cyc(1'b0, 16'h4014, 8'($urandom));
         else cyc(1'($urandom), 16'($urandom), 8'($urandom));
      end
   endtask

   task automatic dma(input logic [7:0] p);
      cyc(1'b0, 16'h4014, p);
      busy(len);
   endtask

   initial begin
      rst = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h8000; cpu_data = 8'h11;
      @(negedge clk); #1;
      check("reset_rdy", 32'(rdy), 32'd1);
      check("reset_act", 32'(act), 32'd0);
      check("reset_addr", 32'(addr), 32'h8000);
      @(negedge clk); #1;
      rst = 1'b0; ncyc = 0;
      cyc(1'b1, 16'h8000, 8'h00);
      cyc(1'b0, 16'h0300, 8'h5A);
      cyc(1'b1, 16'h4014, 8'h02);
      cyc(1'b0, 16'h4015, 8'h07);
      idle(5);
      dma(8'h02);
      idle(3);
      dma(8'h02);
      idle(4);
      dma(8'hFF);
      idle(3);
      dma(8'($urandom));
      idle(2);
      cyc(1'b0, 16'h4014, 8'h03);
      busy(250);
      rst = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'hC123; cpu_data = 8'h3C;
      #1;
      check("abort_rdy", 32'(rdy), 32'd1);
      check("abort_act", 32'(act), 32'd0);
      check("abort_addr", 32'(addr), 32'hC123);
      check("abort_rw", 32'(rw), 32'd1);
      check("abort_data", 32'(dout), 32'h3C);
      q.delete();
      left = 0;
      @(negedge clk); @(negedge clk); #1;
      rst = 1'b0; ncyc = 0;
      idle(40);
      dma(8'h80);
      idle(3);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
